demux_stream_1ton: RTL and testbench
====================================

// Module: demux_stream_1toN
//
// PURPOSE
//  Registered, flow-controlled 1-to-N demultiplexer for packet streams.
//  Routes each packet on one valid/ready input to one of N valid/ready outputs.
//  The route is selected by in_sel on the first beat and locked until in_last.
//  Sits between a single producer and N per-channel consumers.
//  Successor of the combinational 1-to-N demux; adds data width, backpressure, packet lock and drop logic.
//
// PARAMETERS
//  N      8   number of output channels (>=2, need not be a power of 2)
//  W      8   data width per beat
//  SEL_W  3   select width = $clog2(N), fixed by the instantiator
//  CNT_W  8   width of the dropped-packet counter
//
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous active-low reset
//  in_valid   in   1        input beat valid
//  in_ready   out  1        input beat accepted when in_valid & in_ready
//  in_data    in   W        input beat data
//  in_sel     in   SEL_W    destination channel; sampled on first beat of a packet only
//  in_last    in   1        final beat of the packet
//  out_valid  out  N        per-channel beat valid
//  out_ready  in   N        per-channel consumer ready
//  out_data   out  N*W      channel i occupies bits [i*W +: W]
//  out_last   out  N        per-channel last flag
//  drop_cnt   out  CNT_W    count of packets dropped for out-of-range select
//
// BEHAVIOUR
//  - Reset (async, rst_n=0):
//    - out_valid=0, out_data=0, out_last=0, drop_cnt=0, FSM=IDLE, sel_lock=0.
//    - in_ready is combinational; it is 1 after reset, since every slot is empty.
//  - Each channel has a one-entry output register (slot). out_* are driven only from the slots.
//  - Latency: an accepted beat appears on out_* of its channel on the next cycle.
//  - Effective select: sel_eff = (FSM==PKT) ? sel_lock : in_sel.
//  - in_ready:
//    - 1 when sel_eff >= N (drop path).
//    - Otherwise !out_valid[sel_eff] | out_ready[sel_eff].
//    - Never depends on in_valid.
//  - Slot i loads when a beat is accepted and sel_eff==i. It clears when out_valid[i] & out_ready[i] and no load occurs.
//  - Load and drain on the same slot in the same cycle: the new beat replaces the old one and out_valid stays 1.
//  - FSM:
//    - IDLE: accepted beat with in_last=0 -> PKT and sel_lock<=in_sel.
//    - IDLE: accepted beat with in_last=1 -> single-beat packet, stay IDLE.
//    - PKT: accepted beat with in_last=1 -> IDLE. in_sel is ignored throughout PKT.
//  - Out-of-range select (sel_eff >= N):
//    - Every beat of the packet is accepted and discarded; no out_valid is raised.
//    - drop_cnt +1 on the accepted last beat, saturating at 2^CNT_W-1.
//  - Once valid, a channel holds out_data/out_last stable until out_ready; there is no retraction.
//  - Stalled channel: other channels keep draining, but the input stalls while the stalled channel is targeted.
//  - Reset mid-packet: the partial packet is lost, all slots are emptied, FSM returns to IDLE.
//
// STRUCTURE
//  - Shared package demux_pkg holds the FSM state encoding (IDLE=1'b0, PKT=1'b1) and a clog2 helper function for SEL_W.
//  - Sub-module demux_out_slot (one-entry register plus load/drain logic) is generated N times.
//  - The top level holds the FSM, sel_lock, in_ready decode and drop_cnt.
//
// TESTING
//  1. Reset then sweep in_sel=0..7, one single-beat packet each (in_data=8'hA0+sel, out_ready all 1).
//     -> Exactly one out_valid bit per beat, one cycle later, carrying the matching data.
//  2. 3-beat packet with in_sel=2; in_sel changes to 5 on beats 2 and 3.
//     -> All 3 beats are on channel 2; out_last[2]=1 only on beat 3; channel 5 is idle.
//  3. out_ready[4]=0, send 2 beats to channel 4.
//     -> First beat holds on channel 4 and in_ready=0 for the second.
//     -> After out_ready[4]=1 the second beat follows the next cycle, with no loss or duplicate.
//  4. N=6, packets with in_sel=6 and 7 (2 beats each).
//     -> in_ready=1 throughout, no out_valid, drop_cnt=2.
//     -> With CNT_W=2, 5 dropped packets -> drop_cnt saturates at 3.
//  5. Back-to-back beats to channel 1 with out_ready[1]=1.
//     -> Full throughput: one beat per cycle and out_valid[1] held high continuously.
//  6. Assert rst_n=0 mid-packet on channel 3 while out_valid[3]=1.
//     -> out_valid=0 immediately; the next beat with in_sel=0 routes to channel 0.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared definitions for the registered 1-to-N stream demultiplexer.
//   state_t : packet-lock FSM encoding (IDLE = between packets, PKT = inside a packet)
//   clog2   : elaboration-time helper used to size the channel select
package demux_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } state_t;

  // Ceiling log2, with a minimum of 1 for any value >= 2.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/demux_out_slot.sv
// One-entry output register for a single demux channel.
//   clk, rst_n          : clock, asynchronous active-low reset
//   load                : capture load_data/load_last this cycle
//   load_data/load_last : beat to capture
//   ready               : consumer ready for this channel
//   valid/data/last     : registered channel outputs
// A load always wins over a drain, so a simultaneous drain+load keeps valid high
// and replaces the beat, giving one beat per cycle of throughput.
module demux_out_slot
  import demux_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         load_last,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         last
);

  logic         valid_reg, valid_next;
  logic [W-1:0] data_reg, data_next;
  logic         last_reg, last_next;

  always_comb begin
    valid_next = valid_reg;
    data_next  = data_reg;
    last_next  = last_reg;
    if (load) begin
      valid_next = 1'b1;
      data_next  = load_data;
      last_next  = load_last;
    end else if (ready) begin
      valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
      last_reg  <= 1'b0;
    end else begin
      valid_reg <= valid_next;
      data_reg  <= data_next;
      last_reg  <= last_next;
    end
  end

  assign valid = valid_reg;
  assign data  = data_reg;
  assign last  = last_reg;

endmodule

// File: rtl/demux_stream_1ton.sv
// Registered, flow-controlled 1-to-N packet demultiplexer.
//   clk, rst_n         : clock, asynchronous active-low reset
//   in_valid/in_ready  : input handshake; in_ready is combinational and ignores in_valid
//   in_data, in_last   : input beat payload and end-of-packet flag
//   in_sel             : destination channel, sampled on the first beat only
//   out_valid/out_ready: per-channel handshakes
//   out_data           : channel i on bits [i*W +: W]
//   out_last           : per-channel end-of-packet flag
//   drop_cnt           : saturating count of packets discarded for an out-of-range select
module demux_stream_1ton
  import demux_pkg::*;
#(
  parameter int N     = 8,
  parameter int W     = 8,
  parameter int SEL_W = clog2(N),
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic [SEL_W-1:0] in_sel,
  input  logic             in_last,
  output logic [N-1:0]     out_valid,
  input  logic [N-1:0]     out_ready,
  output logic [N*W-1:0]   out_data,
  output logic [N-1:0]     out_last,
  output logic [CNT_W-1:0] drop_cnt
);

  // One extra bit so the range compare also works when N is a power of two.
  localparam logic [SEL_W:0] N_LIM = (SEL_W + 1)'(N);

  state_t             state_reg, state_next;
  logic [SEL_W-1:0]   sel_lock_reg, sel_lock_next;
  logic [CNT_W-1:0]   drop_cnt_reg, drop_cnt_next;
  logic [SEL_W-1:0]   sel_eff;
  logic               in_range;
  logic               accept;
  logic [N-1:0]       target;
  logic [N-1:0]       slot_open;
  logic [N-1:0]       load;

  // Inside a packet the locked channel is used and in_sel is ignored.
  assign sel_eff  = (state_reg == PKT) ? sel_lock_reg : in_sel;
  assign in_range = ({1'b0, sel_eff} < N_LIM);

  // Out-of-range beats are always accepted so they can be discarded;
  // otherwise only the targeted slot's occupancy matters.
  assign in_ready = ~in_range | (|(target & slot_open));
  assign accept   = in_valid & in_ready;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_slot
      assign target[gi]    = (sel_eff == SEL_W'(gi));
      assign slot_open[gi] = ~out_valid[gi] | out_ready[gi];
      assign load[gi]      = accept & target[gi];

      demux_out_slot #(
        .W (W)
      ) u_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load[gi]),
        .load_data (in_data),
        .load_last (in_last),
        .ready     (out_ready[gi]),
        .valid     (out_valid[gi]),
        .data      (out_data[gi*W +: W]),
        .last      (out_last[gi])
      );
    end
  endgenerate

  always_comb begin
    state_next    = state_reg;
    sel_lock_next = sel_lock_reg;
    if (accept) begin
      if (in_last) begin
        state_next = IDLE;
      end else if (state_reg == IDLE) begin
        state_next    = PKT;
        sel_lock_next = in_sel;
      end
    end
  end

  always_comb begin
    drop_cnt_next = drop_cnt_reg;
    if (accept && !in_range && in_last && (drop_cnt_reg != {CNT_W{1'b1}})) begin
      drop_cnt_next = drop_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      sel_lock_reg <= '0;
      drop_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      sel_lock_reg <= sel_lock_next;
      drop_cnt_reg <= drop_cnt_next;
    end
  end

  assign drop_cnt = drop_cnt_reg;

endmodule

// File: tb/tb_demux_stream_1ton.sv
// Bench for demux_stream_1ton: instance 0 uses N=8/CNT_W=8, instance 1 uses
// N=6/CNT_W=2 to exercise the drop path and counter saturation.
// A queue-per-channel model predicts every output each cycle.
module tb_demux_stream_1ton;

  logic       clk;
  logic       rst_n;
  logic       in_valid_s [2];
  logic [2:0] in_sel_s   [2];
  logic [7:0] in_data_s  [2];
  logic       in_last_s  [2];
  logic [7:0] out_ready_s[2];

  logic        ir_a, ir_b;
  logic [7:0]  ov_a, ol_a, dc_a;
  logic [63:0] od_a;
  logic [5:0]  ov_b, ol_b;
  logic [47:0] od_b;
  logic [1:0]  dc_b;

  logic [7:0]  ov_s[2], ol_s[2], dc_s[2];
  logic [63:0] od_s[2];
  logic        ir_s[2];

  assign ov_s[0] = ov_a;
  assign ov_s[1] = {2'b00, ov_b};
  assign ol_s[0] = ol_a;
  assign ol_s[1] = {2'b00, ol_b};
  assign od_s[0] = od_a;
  assign od_s[1] = {16'h0, od_b};
  assign dc_s[0] = dc_a;
  assign dc_s[1] = {6'b0, dc_b};
  assign ir_s[0] = ir_a;
  assign ir_s[1] = ir_b;

  demux_stream_1ton #(.N(8), .W(8), .SEL_W(3), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_s[0]), .in_ready(ir_a), .in_data(in_data_s[0]),
    .in_sel(in_sel_s[0]), .in_last(in_last_s[0]),
    .out_valid(ov_a), .out_ready(out_ready_s[0]), .out_data(od_a),
    .out_last(ol_a), .drop_cnt(dc_a)
  );

  demux_stream_1ton #(.N(6), .W(8), .SEL_W(3), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_s[1]), .in_ready(ir_b), .in_data(in_data_s[1]),
    .in_sel(in_sel_s[1]), .in_last(in_last_s[1]),
    .out_valid(ov_b), .out_ready(out_ready_s[1][5:0]), .out_data(od_b),
    .out_last(ol_b), .drop_cnt(dc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each channel is a queue of {last,data}; a non-empty queue means that
  // channel must be presenting its front entry.
  logic [8:0] mq [2][8][$];
  bit         m_pkt [2] = '{0, 0};
  logic [2:0] m_lock[2] = '{3'd0, 3'd0};
  int         m_drop[2] = '{0, 0};
  bit         m_acc [2] = '{0, 0};

  function automatic int nch(input int k);
    return (k == 0) ? 8 : 6;
  endfunction

  function automatic int cmax(input int k);
    return (k == 0) ? 255 : 3;
  endfunction

  function automatic logic [2:0] m_sel(input int k);
    return m_pkt[k] ? m_lock[k] : in_sel_s[k];
  endfunction

  function automatic bit m_ready(input int k);
    int s;
    s = int'(m_sel(k));
    if (s >= nch(k)) return 1'b1;
    return (mq[k][s].size() == 0) || out_ready_s[k][s];
  endfunction

  int  ms;
  bit  macc;
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      for (int k = 0; k < 2; k++) begin
        if (!rst_n) begin
          for (int i = 0; i < 8; i++) mq[k][i].delete();
          m_pkt[k]  = 0;
          m_drop[k] = 0;
          m_acc[k]  = 0;
        end else begin
          ms   = int'(m_sel(k));
          macc = in_valid_s[k] && m_ready(k);
          for (int i = 0; i < nch(k); i++)
            if (mq[k][i].size() > 0 && out_ready_s[k][i]) void'(mq[k][i].pop_front());
          if (macc) begin
            if (ms < nch(k)) mq[k][ms].push_back({in_last_s[k], in_data_s[k]});
            else if (in_last_s[k] && m_drop[k] < cmax(k)) m_drop[k]++;
            if (in_last_s[k]) m_pkt[k] = 0;
            else if (!m_pkt[k]) begin
              m_pkt[k]  = 1;
              m_lock[k] = in_sel_s[k];
            end
          end
          m_acc[k] = macc;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [7:0] em;
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      em = 8'h00;
      for (int i = 0; i < 8; i++) if (mq[k][i].size() > 0) em[i] = 1'b1;
      chk($sformatf("out_valid[dut%0d]", k), 64'(ov_s[k]), 64'(em));
      for (int i = 0; i < 8; i++)
        if (em[i]) chk($sformatf("beat[dut%0d ch%0d]", k, i),
                       64'({ol_s[k][i], od_s[k][i*8 +: 8]}), 64'(mq[k][i][0]));
      chk($sformatf("in_ready[dut%0d]", k), 64'(ir_s[k]), 64'(m_ready(k)));
      chk($sformatf("drop_cnt[dut%0d]", k), 64'(dc_s[k]), 64'(m_drop[k]));
    end
  end

  // ---------------- stimulus ----------------
  bit rnd = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd) begin
      out_ready_s[0] = 8'($urandom) | 8'($urandom);
      out_ready_s[1] = 8'($urandom) | 8'($urandom);
    end
  endtask

  task automatic drive_beat(input int k, input logic [2:0] sel, input logic [7:0] data,
                            input logic last, output int cyc);
    in_valid_s[k] = 1'b1;
    in_sel_s[k]   = sel;
    in_data_s[k]  = data;
    in_last_s[k]  = last;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!m_acc[k] && cyc < 100);
    if (!m_acc[k]) chk("accept_timeout", 64'(0), 64'(1));
    in_valid_s[k] = 1'b0;
    $display("beat dut%0d sel=%0d data=%02h last=%0b cycles=%0d", k, sel, data, last, cyc);
  endtask

  int cyc;
  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid_s[k] = 1'b0;
      in_sel_s[k]   = 3'd0;
      in_data_s[k]  = 8'h00;
      in_last_s[k]  = 1'b0;
      out_ready_s[k] = 8'hFF;
    end
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst out_valid", 64'(ov_a), 64'(0));
    chk("rst out_data", od_a, 64'(0));
    chk("rst out_last", 64'(ol_a), 64'(0));
    chk("rst drop_cnt", 64'(dc_a), 64'(0));
    chk("rst in_ready", 64'(ir_a), 64'(1));
    chk("rst out_valid_b", 64'(ov_b), 64'(0));

    // 1: single-beat sweep over all channels
    for (int s = 0; s < 8; s++) begin
      drive_beat(0, 3'(s), 8'hA0 + 8'(s), 1'b1, cyc);
      chk("sweep onehot", 64'(ov_a), 64'(8'h01 << s));
      chk("sweep data", 64'(od_a[s*8 +: 8]), 64'(8'hA0 + 8'(s)));
    end
    tick();

    // 2: select locked for the whole packet
    drive_beat(0, 3'd2, 8'h21, 1'b0, cyc);
    chk("lock ch2 b1", 64'({ov_a, ol_a[2]}), 64'({8'h04, 1'b0}));
    drive_beat(0, 3'd5, 8'h22, 1'b0, cyc);
    chk("lock ch2 b2", 64'({ov_a, ol_a[2]}), 64'({8'h04, 1'b0}));
    drive_beat(0, 3'd5, 8'h23, 1'b1, cyc);
    chk("lock ch2 b3", 64'({ov_a, ol_a[2], od_a[23:16]}), 64'({8'h04, 1'b1, 8'h23}));
    tick();

    // 3: stalled channel 4 holds its beat and back-pressures the input
    out_ready_s[0] = 8'hEF;
    drive_beat(0, 3'd4, 8'h41, 1'b0, cyc);
    in_valid_s[0] = 1'b1;
    in_sel_s[0]   = 3'd7;
    in_data_s[0]  = 8'h42;
    in_last_s[0]  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("stall in_ready", 64'(ir_a), 64'(0));
      tick();
      chk("stall hold", 64'({ov_a[4], od_a[39:32]}), 64'({1'b1, 8'h41}));
    end
    out_ready_s[0] = 8'hFF;
    drive_beat(0, 3'd7, 8'h42, 1'b1, cyc);
    chk("stall release cycles", 64'(cyc), 64'(1));
    chk("stall second beat", 64'({ov_a, od_a[39:32], ol_a[4]}), 64'({8'h10, 8'h42, 1'b1}));
    tick();

    // 4: out-of-range selects are dropped and counted (N=6, CNT_W=2)
    drive_beat(1, 3'd6, 8'h61, 1'b0, cyc);
    chk("drop ready", 64'(cyc), 64'(1));
    drive_beat(1, 3'd2, 8'h62, 1'b1, cyc);
    chk("drop ready", 64'(cyc), 64'(1));
    drive_beat(1, 3'd7, 8'h71, 1'b0, cyc);
    drive_beat(1, 3'd7, 8'h72, 1'b1, cyc);
    chk("drop no valid", 64'(ov_b), 64'(0));
    chk("drop count 2", 64'(dc_b), 64'(2));
    for (int i = 0; i < 3; i++) drive_beat(1, 3'd6, 8'h60, 1'b1, cyc);
    chk("drop saturate", 64'(dc_b), 64'(3));
    drive_beat(1, 3'd5, 8'h55, 1'b1, cyc);
    chk("in-range after drops", 64'({ov_b, od_b[47:40]}), 64'({6'h20, 8'h55}));
    tick();

    // 5: back-to-back beats at full throughput
    for (int i = 0; i < 4; i++) begin
      drive_beat(0, 3'd1, 8'h10 + 8'(i), (i == 3), cyc);
      chk("throughput cycles", 64'(cyc), 64'(1));
      chk("throughput valid", 64'({ov_a[1], od_a[15:8]}), 64'({1'b1, 8'h10 + 8'(i)}));
    end
    tick();

    // 6: reset in the middle of a packet on channel 3
    out_ready_s[0] = 8'hF7;
    drive_beat(0, 3'd3, 8'h33, 1'b0, cyc);
    #1;
    chk("pre-reset valid", 64'(ov_a[3]), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("reset clears valid", 64'(ov_a), 64'(0));
    tick();
    rst_n = 1'b1;
    out_ready_s[0] = 8'hFF;
    drive_beat(0, 3'd0, 8'h5A, 1'b1, cyc);
    chk("post-reset route", 64'({ov_a, od_a[7:0]}), 64'({8'h01, 8'h5A}));
    tick();

    // Randomized traffic on both instances
    rnd = 1;
    for (int p = 0; p < 160; p++) begin
      int k;
      int len;
      logic [2:0] sel;
      k   = p % 2;
      len = $urandom_range(1, 4);
      sel = 3'($urandom_range(0, 7));
      for (int b = 0; b < len; b++) begin
        drive_beat(k, (b == 0) ? sel : 3'($urandom_range(0, 7)), 8'($urandom), (b == len - 1), cyc);
      end
      for (int i = 0; i < int'($urandom_range(0, 2)); i++) tick();
    end
    rnd = 0;
    out_ready_s[0] = 8'hFF;
    out_ready_s[1] = 8'hFF;
    tick();
    tick();
    chk("drain all a", 64'(ov_a), 64'(0));
    chk("drain all b", 64'(ov_b), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
